ram_dp_clr: RTL

- Parametrised successor to the Hack 16K data RAM.
- Same write/read port A as the original RAM interface, plus:
  - an independent read-only port B (e.g. screen/display fetch);
  - a selectable read latency;
  - a hardware clear engine that zero-fills the array after reset. Intel RAM blocks cannot be cleared by a reset branch, so the clear is done by sweeping writes.
- Sits between the CPU data bus / memory map and the display controller.

---
 rtl/ram_dp_clr_pkg.sv | 20 ++
 rtl/ram_dp_core.sv | 50 +++++
 rtl/ram_dp_clr.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ram_dp_clr_pkg.sv
// Shared types and elaboration helpers for the dual-port clearable data RAM.
//   state_e       : controller state (sweep in progress / normal operation)
//   depth_of      : number of words addressed by an address of the given width
//   rd_latency_ok : legality of a read-latency setting (0 or 1 only)
package ram_dp_clr_pkg;

  typedef enum logic {
    StClear = 1'b0,
    StIdle  = 1'b1
  } state_e;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic bit rd_latency_ok(input int unsigned lat);
    return lat <= 32'd1;
  endfunction

endpackage

// File: rtl/ram_dp_core.sv
// Inferrable storage array: one write port, two read ports, no reset.
//   clock            : write and (for RD_LATENCY=1) read register clock
//   we/waddr/wdata   : write port
//   raddr_a / q_a    : read port A; write-first when RD_LATENCY=1
//   raddr_b / q_b    : read port B; read-first when RD_LATENCY=1 (no bypass)
module ram_dp_core
  import ram_dp_clr_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned RD_LATENCY = 0
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b
);

  localparam int unsigned Depth = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  if (RD_LATENCY == 0) begin : gen_comb_read
    assign q_a = mem[raddr_a];
    assign q_b = mem[raddr_b];
  end else begin : gen_reg_read
    logic [DATA_W-1:0] q_a_q;
    logic [DATA_W-1:0] q_b_q;

    // Port A forwards its own same-cycle write; port B deliberately sees old data.
    always_ff @(posedge clock) begin
      q_a_q <= (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
      q_b_q <= mem[raddr_b];
    end

    assign q_a = q_a_q;
    assign q_b = q_b_q;
  end

endmodule

// File: rtl/ram_dp_clr.sv
// Dual-port data RAM with hardware clear sweep after reset.
//   clock      : single clock, rising edge
//   aclr       : asynchronous active-high reset (array contents are not reset)
//   address    : port A address, data/wren : port A write, q : port A read data
//   address_b  : port B read address, q_b : port B read data
//   busy       : clear sweep running; port accesses blocked, reads return CLEAR_VALUE
//   wr_dropped : sticky, set by a wren seen while busy, cleared only by aclr
module ram_dp_clr
  import ram_dp_clr_pkg::*;
#(
  parameter int unsigned       DATA_W         = 16,
  parameter int unsigned       ADDR_W         = 14,
  parameter int unsigned       RD_LATENCY     = 0,
  parameter int unsigned       CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  input  logic [ADDR_W-1:0] address_b,
  output logic [DATA_W-1:0] q_b,
  output logic              busy,
  output logic              wr_dropped
);

  if (!rd_latency_ok(RD_LATENCY)) begin : gen_bad_latency
    $error("ram_dp_clr: RD_LATENCY must be 0 or 1");
  end

  localparam state_e ResetState = (CLEAR_ON_RESET != 0) ? StClear : StIdle;
  // One extra bit keeps the terminal compare exact at the top of the array.
  localparam logic [ADDR_W:0] ClrLast = {1'b0, {ADDR_W{1'b1}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   clr_addr_q, clr_addr_d;
  logic              wr_dropped_q, wr_dropped_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] core_q_a, core_q_b;
  logic [DATA_W-1:0] rd_q_a, rd_q_b;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q      <= ResetState;
      clr_addr_q   <= '0;
      wr_dropped_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      wr_dropped_q <= wr_dropped_d;
    end
  end

  assign busy = (state_q == StClear);

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    mem_we       = 1'b0;
    mem_waddr    = address;
    mem_wdata    = data;
    wr_dropped_d = wr_dropped_q | (busy & wren);
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q[ADDR_W-1:0];
        mem_wdata = CLEAR_VALUE;
        if (clr_addr_q == ClrLast) begin
          state_d    = StIdle;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      StIdle: begin
        mem_we = wren;
      end
    endcase
  end

  ram_dp_core #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .RD_LATENCY(RD_LATENCY)
  ) u_core (
    .clock  (clock),
    .we     (mem_we),
    .waddr  (mem_waddr),
    .wdata  (mem_wdata),
    .raddr_a(address),
    .raddr_b(address_b),
    .q_a    (core_q_a),
    .q_b    (core_q_b)
  );

  if (RD_LATENCY == 0) begin : gen_out_comb
    assign rd_q_a = core_q_a;
    assign rd_q_b = core_q_b;
  end else begin : gen_out_reg
    // The core's read registers have no reset; this flag makes them read as
    // zero from aclr until the first edge reloads them.
    logic rd_valid_q;

    always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= 1'b1;
      end
    end

    assign rd_q_a = rd_valid_q ? core_q_a : '0;
    assign rd_q_b = rd_valid_q ? core_q_b : '0;
  end

  assign q          = busy ? CLEAR_VALUE : rd_q_a;
  assign q_b        = busy ? CLEAR_VALUE : rd_q_b;
  assign wr_dropped = wr_dropped_q;

endmodule
